// File: rtl/gray_ptr_pkg.sv
// Shared types and helpers for the Gray pointer synchroniser.
// Helpers work on MaxWidth-bit zero-extended vectors; WIDTH must not exceed MaxWidth.
package gray_ptr_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [0:0] {Idle, Settle} state_e;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_n_sync_chain.sv
// sync_chain: WIDTH-wide, STAGES-deep synchroniser flop chain.
module sync_chain
  import gray_ptr_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s_q [STAGES];

  // Shift the foreign-domain value through the chain every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < STAGES; i++) s_q[i] <= '0;
    end else begin
      s_q[0] <= d;
      for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1];
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_n.sv
// gray_ptr_sync_n: multi-stage Gray pointer synchroniser with optional stability
// filter, registered binary conversion and update pulse with pointer delta.
// Define GRAY_PTR_SYNC_CHECK_EN to enable the sticky multi-bit-change flag.
module gray_ptr_sync_n
  import gray_ptr_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILTER = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] ASYNC_GRAY,
  output logic [WIDTH-1:0] SYNC_GRAY,
  output logic [WIDTH-1:0] SYNC_BIN,
  output logic             PTR_UPD,
  output logic [WIDTH-1:0] STEP,
  output logic             GRAY_ERR
);

  localparam int unsigned CntW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] s_bin;
  logic             load;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] sync_gray_q, sync_bin_q, step_q;
  logic             ptr_upd_q;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync_chain (
    .CLK (CLK),
    .RST (RST),
    .d   (ASYNC_GRAY),
    .q   (s_last)
  );

  assign s_bin = WIDTH'(gray2bin(MaxWidth'(s_last)));

  // Filter FSM: decide when the synchronised value has been stable long enough to load.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (FILTER == 0) begin
      load = (s_last != sync_gray_q);
    end else begin
      unique case (state_q)
        Idle: begin
          if (s_last != sync_gray_q) begin
            cand_d  = s_last;
            cnt_d   = CntW'(1);
            state_d = Settle;
          end
        end
        Settle: begin
          if (s_last != cand_q) begin
            if (s_last == sync_gray_q) begin
              state_d = Idle;
            end else begin
              cand_d = s_last;
              cnt_d  = CntW'(1);
            end
          end else if (cnt_q == CntW'(FILTER)) begin
            load    = 1'b1;
            state_d = Idle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  // FSM and candidate registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= Idle;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers: all update together on a load; the pulse clears otherwise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_gray_q <= '0;
      sync_bin_q  <= '0;
      step_q      <= '0;
      ptr_upd_q   <= 1'b0;
    end else begin
      ptr_upd_q <= load;
      if (load) begin
        sync_gray_q <= s_last;
        sync_bin_q  <= s_bin;
        step_q      <= s_bin - sync_bin_q;
      end
    end
  end

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic gray_err_q;

  // Sticky flag: a load that changes more than one Gray bit at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gray_err_q <= 1'b0;
    end else if (load && (popcount(MaxWidth'(s_last ^ sync_gray_q)) > 1)) begin
      gray_err_q <= 1'b1;
    end
  end

  assign GRAY_ERR = gray_err_q;
`else
  assign GRAY_ERR = 1'b0;
`endif

  assign SYNC_GRAY = sync_gray_q;
  assign SYNC_BIN  = sync_bin_q;
  assign STEP      = step_q;
  assign PTR_UPD   = ptr_upd_q;

endmodule

// File: doc/gray_ptr_sync_n.md
# gray_ptr_sync_n

Parametrised multi-stage synchroniser for Gray-coded FIFO pointers crossing into the CLK domain. It extends the fixed two-flop pointer synchroniser with:
- configurable depth and width
- an optional stability filter
- registered Gray-to-binary conversion
- an update pulse with pointer delta, for occupancy counters in the async FIFO read/write controllers

## Interface
- WIDTH, 4: pointer width in bits, ≥2.
- STAGES, 2: synchroniser flops per bit, ≥2.
- FILTER, 0: extra consecutive stable cycles required before output update; 0 = no filter.
- CLK  in  1  destination-domain clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ASYNC_GRAY  in  WIDTH  Gray pointer from foreign domain; may change at any time.
- SYNC_GRAY  out  WIDTH  synchronised, filtered Gray pointer.
- SYNC_BIN  out  WIDTH  binary equivalent of SYNC_GRAY, same cycle.
- PTR_UPD  out  1  one-cycle pulse when SYNC_GRAY takes a new value.
- STEP  out  WIDTH  (new_bin − old_bin) mod 2^WIDTH of the latest update; holds between updates.
- GRAY_ERR  out  1  sticky Gray-violation flag (see Configuration).

## Operation
- Chain s[0..STAGES-1] per bit: s[0] ← ASYNC_GRAY, s[i] ← s[i-1]. s_last = s[STAGES-1].
- Load: SYNC_GRAY ← s_last, SYNC_BIN ← gray2bin(s_last), STEP ← gray2bin(s_last) − SYNC_BIN (mod 2^WIDTH), PTR_UPD ← 1. All assignments happen on one edge.
- FSM states IDLE, SETTLE. Registers cand[WIDTH], cnt[max(1,$clog2(FILTER+1))].
- FILTER=0: every edge with s_last ≠ SYNC_GRAY performs a load. FSM stays in IDLE.
- FILTER>0:
  - IDLE: if s_last ≠ SYNC_GRAY: cand ← s_last, cnt ← 1, go to SETTLE.
  - SETTLE, s_last ≠ cand: if s_last = SYNC_GRAY, go to IDLE. Otherwise cand ← s_last, cnt ← 1.
  - SETTLE, s_last = cand, cnt = FILTER: load, go to IDLE.
  - SETTLE, otherwise: cnt ← cnt+1.
- PTR_UPD is 0 on every non-load cycle. STEP and SYNC_* hold.
- Wrap-around: STEP arithmetic is modulo 2^WIDTH. Example: bin 15 → 0 gives STEP = 1.
- Reset values: s[*], SYNC_GRAY, SYNC_BIN, STEP, cand, cnt = 0. PTR_UPD = 0, GRAY_ERR = 0, state IDLE.
- Reset mid-SETTLE abandons the candidate. After reset release, a nonzero ASYNC_GRAY is treated as a normal update from 0.

## Timing
- ASYNC_GRAY stable before edge 1 → s_last valid at edge STAGES → SYNC_GRAY, SYNC_BIN, STEP, PTR_UPD at edge STAGES+1+FILTER.
- Input glitch shorter than FILTER+1 cycles at s_last: no update, no pulse.
- Back-to-back legal increments each ≥ FILTER+1 cycles apart: one PTR_UPD per increment.
- Faster increments coalesce into a single PTR_UPD with STEP > 1.
- Throughput: at most one load per cycle when FILTER=0.

## Configuration
- GRAY_PTR_SYNC_CHECK_EN defined: on each load, if popcount(s_last XOR SYNC_GRAY) > 1, GRAY_ERR ← 1. The flag is sticky until RST.
- GRAY_PTR_SYNC_CHECK_EN not defined: the check logic is absent and GRAY_ERR is tied to 0. The port stays present.

## Structure
- Shared package gray_ptr_pkg holds:
  - function gray2bin(WIDTH-generic via loop)
  - function popcount
  - FSM state typedef {IDLE, SETTLE}
- Sub-module sync_chain: WIDTH-wide × STAGES-deep flop chain with async active-low reset. Instantiated once.

## Test plan
- Reset/start (WIDTH=4, STAGES=2, FILTER=0): hold RST=0 with ASYNC_GRAY=0001 → all outputs 0. Release → at edge 3, SYNC_GRAY=0001, SYNC_BIN=0001, STEP=1, PTR_UPD=1 for one cycle, GRAY_ERR=0.
- Full Gray count 0→15→0, one step every 4 cycles → 16 PTR_UPD pulses, each STEP=1. Wrap 1000→0000 gives SYNC_BIN 15→0 with STEP=1 and GRAY_ERR=0.
- FILTER=3:
  - ASYNC_GRAY 0000→0001 for 2 cycles, then back to 0000 → no PTR_UPD, SYNC_GRAY stays 0000.
  - Held at 0001 → update exactly at edge 6 after the change.
- Illegal jump 0000→0011 with GRAY_PTR_SYNC_CHECK_EN → PTR_UPD=1, SYNC_BIN=0010, STEP=2, GRAY_ERR=1 and stays 1 across later legal updates until RST. Same stimulus without the macro → GRAY_ERR=0.
- Burst: 4 increments in 4 consecutive cycles with FILTER=0, STAGES=3 → first update at edge 4, then 3 more pulses each STEP=1. Repeat with FILTER=2 → single update, STEP=4.
- RST asserted while in SETTLE (FILTER=3, cnt=2) → outputs 0 immediately, no PTR_UPD after release until a new stable value propagates.
